// File: rtl/pool_stream_unit.sv
// Streaming WINDOW x WINDOW max/sum pooling engine with valid/ready ports.
// Define POOL_AVG_EN to enable mode 10 (average = floored sum >> log2(N)).
module pool_stream_unit #(
  parameter int WINDOW = 4,
  parameter int DATA_W = 32,
  parameter int OUT_W  = DATA_W + $clog2(WINDOW * WINDOW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_mode
);

  localparam int N  = WINDOW * WINDOW;
  localparam int CW = $clog2(N);

`ifdef POOL_AVG_EN
  localparam int SH = $clog2(N);
  if ((WINDOW & (WINDOW - 1)) != 0) begin : g_win_chk
    $error("pool_stream_unit: WINDOW must be a power of two for averaging");
  end
`endif

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic signed [OUT_W-1:0]  acc;
  logic [1:0]               mode_q;
  logic [1:0]               mode_n;
  logic signed [OUT_W-1:0]  in_ext;
  logic signed [OUT_W-1:0]  nxt;
  logic signed [OUT_W-1:0]  res;
  logic                     accept;
  logic                     last;

  assign last     = (count == CW'(N - 1));
  assign in_ready = !(out_valid && !out_ready && last);
  assign accept   = in_valid && in_ready;
  assign in_ext   = {{(OUT_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // Fold reserved/disabled modes onto max so out_mode reports what was computed.
  always_comb begin
    mode_n = 2'b00;
    if (mode == 2'b01) begin
      mode_n = 2'b01;
    end
`ifdef POOL_AVG_EN
    else if (mode == 2'b10) begin
      mode_n = 2'b10;
    end
`endif
  end

  // Next accumulator value and the final result for the closing element.
  always_comb begin
    nxt = acc + in_ext;
    if (mode_q == 2'b00) begin
      nxt = (in_ext > acc) ? in_ext : acc;
    end
    res = nxt;
`ifdef POOL_AVG_EN
    if (mode_q == 2'b10) begin
      res = nxt >>> SH;
    end
`endif
  end

  // Window FSM, accumulator and registered output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mode_q    <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 2'b00;
    end else if (clear) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        unique case (state)
          IDLE: begin
            mode_q <= mode_n;
            acc    <= in_ext;
            count  <= CW'(1);
            state  <= ACCUM;
          end
          ACCUM: begin
            if (last) begin
              out_data  <= res;
              out_mode  <= mode_q;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= IDLE;
            end else begin
              acc   <= nxt;
              count <= count + CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Directed testbench for pool_stream_unit (WINDOW=4, DATA_W=32, OUT_W=36).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_pool_stream_unit;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [35:0] out_data;
  logic [1:0]         out_mode;

  int tests = 0;
  int fails = 0;

  pool_stream_unit #(.WINDOW(4), .DATA_W(32), .OUT_W(36)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; mode = 2'b00;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    tests++;
    if (out_data !== 36'sd0) begin
      fails++; $display("FAIL reset_data got %0d want 0", out_data);
    end
    tests++;
    if (out_mode !== 2'b00) begin
      fails++; $display("FAIL reset_mode got %0b want 00", out_mode);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_max();
    mode = 2'b00; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) push(-32'sd5);
      else if (i == 9) push(32'd100);
      else push(i);
      if (i == 14) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++; $display("FAIL max_early got %0b want 0", out_valid);
        end
      end
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd100) begin
      fails++;
      $display("FAIL max_data got v=%0b d=%0d want v=1 d=100", out_valid, out_data);
    end
    tests++;
    if (out_mode !== 2'b00) begin
      fails++; $display("FAIL max_mode got %0b want 00", out_mode);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL max_drain got %0b want 0", out_valid);
    end
    for (int i = 0; i < 16; i++) push(-3 - i);
    tests++;
    if (out_valid !== 1'b1 || out_data !== -36'sd3) begin
      fails++;
      $display("FAIL max_neg got v=%0b d=%0d want v=1 d=-3", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_sum();
    mode = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(32'h7FFFFFFF);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sh7FFFFFFF0) begin
      fails++;
      $display("FAIL sum_max got v=%0b d=%0h want v=1 d=7fffffff0", out_valid, out_data);
    end
    tests++;
    if (out_mode !== 2'b01) begin
      fails++; $display("FAIL sum_mode got %0b want 01", out_mode);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc_cnt;
    mode = 2'b01; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'd1);
    in_valid = 1'b1; in_data = 32'd2;
    acc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) acc_cnt++;
      @(negedge clk);
    end
    tests++;
    if (acc_cnt != 15) begin
      fails++; $display("FAIL bp_accepts got %0d want 15", acc_cnt);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_stall got %0b want 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd16) begin
      fails++;
      $display("FAIL bp_hold got v=%0b d=%0d want v=1 d=16", out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release got %0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd32) begin
      fails++;
      $display("FAIL bp_second got v=%0b d=%0d want v=1 d=32", out_valid, out_data);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_mode_change();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mode = (i < 4) ? 2'b01 : 2'b00;
      push(32'd2);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd32 || out_mode !== 2'b01) begin
      fails++;
      $display("FAIL mode_change got v=%0b d=%0d m=%0b want v=1 d=32 m=01",
               out_valid, out_data, out_mode);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    int seen;
    mode = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(32'd5);
    clear = 1'b1;
    push(32'd5);
    clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) seen++;
      push(32'd1);
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL clear_spurious got %0d want 0", seen);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd16) begin
      fails++;
      $display("FAIL clear_fresh got v=%0b d=%0d want v=1 d=16", out_valid, out_data);
    end
    @(negedge clk);
    for (int i = 0; i < 9; i++) push(32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid_valid got %0b want 0", out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) seen++;
      push(32'd1);
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL rst_spurious got %0d want 0", seen);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd16) begin
      fails++;
      $display("FAIL rst_fresh got v=%0b d=%0d want v=1 d=16", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_avg();
    logic signed [35:0] exp1, exp2;
    logic [1:0]         expm;
`ifdef POOL_AVG_EN
    exp1 = -36'sd1; exp2 = -36'sd2; expm = 2'b10;
`else
    exp1 = -36'sd1; exp2 = -36'sd1; expm = 2'b00;
`endif
    mode = 2'b10; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(32'hFFFFFFFF);
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp1 || out_mode !== expm) begin
      fails++;
      $display("FAIL avg_m1 got v=%0b d=%0d m=%0b want v=1 d=%0d m=%0b",
               out_valid, out_data, out_mode, exp1, expm);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(i == 5 ? 32'hFFFFFFFE : 32'hFFFFFFFF);
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp2 || out_mode !== expm) begin
      fails++;
      $display("FAIL avg_m17 got v=%0b d=%0d m=%0b want v=1 d=%0d m=%0b",
               out_valid, out_data, out_mode, exp2, expm);
    end
    @(negedge clk);
    mode = 2'b11;
    for (int i = 0; i < 16; i++) push(i);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 36'sd15 || out_mode !== 2'b00) begin
      fails++;
      $display("FAIL reserved got v=%0b d=%0d m=%0b want v=1 d=15 m=00",
               out_valid, out_data, out_mode);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max();
    test_sum();
    test_back_to_back();
    test_mode_change();
    test_clear();
    test_avg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
